// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg
// Shared definitions for the APB timer peripheral:
//   - register offsets within the 256-byte decode window (paddr_i[7:0])
//   - CTRL register bit positions
//   - APB completer state type
package apb_timer_pkg;

    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] LOAD_OFF   = 8'h04;
    localparam logic [7:0] VALUE_OFF  = 8'h08;
    localparam logic [7:0] STATUS_OFF = 8'h0C;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AR_BIT     = 1;
    localparam int CTRL_IRQ_BIT    = 2;
    localparam int CTRL_PRESC_LSB  = 8;
    localparam int CTRL_PRESC_MSB  = 15;

    localparam int STATUS_OVF_BIT  = 0;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_timer_slave_if.sv
// apb_timer_slave_if
// APB bus bundle between the bridge (master) and the timer completer (slave).
//   psel_i, penable_i, pwrite_i, paddr_i, pwdata_i : requester -> completer
//   prdata_o, pready_o, pslverr_o                  : completer -> requester
// Signal names keep the completer's point of view (_i into it, _o out of it).
interface apb_timer_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

endinterface

// File: rtl/apb_timer_slave_timer_core.sv
// timer_core
// Down-counter of the APB timer.
//   i_clk, i_rstN    : clock, asynchronous active-low reset
//   i_tick           : count enable for this cycle (EN already folded in)
//   i_load           : copy i_loadValue into the counter (timer start)
//   i_loadValue      : reload value (LOAD register)
//   i_autoReload     : on underflow reload from i_loadValue, else hold at 0
//   o_value          : current count
//   o_underflow      : single-cycle pulse, tick taken while count is 0
module timer_core #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rstN,
    input  logic                 i_tick,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_loadValue,
    input  logic                 i_autoReload,
    output logic [CNT_WIDTH-1:0] o_value,
    output logic                 o_underflow
);

    logic [CNT_WIDTH-1:0] r_value;

    assign o_underflow = i_tick && (r_value == '0);
    assign o_value     = r_value;

    // Reload samples i_loadValue before any same-cycle LOAD write lands,
    // so an underflow always reloads the previously programmed value.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_loadValue;
        end else if (i_tick) begin
            if (r_value == '0) begin
                if (i_autoReload) begin
                    r_value <= i_loadValue;
                end
            end else begin
                r_value <= r_value - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave
// APB completer wrapping a down-counting timer with a level interrupt.
//   hclk_i    : clock shared with the APB bridge
//   hreset_i  : asynchronous reset, active-low
//   apb       : APB slave modport (psel/penable/pwrite/paddr/pwdata in,
//               prdata/pready/pslverr out)
//   irq_o     : STATUS.OVF & CTRL.IRQ_EN
// Registers: 0x00 CTRL, 0x04 LOAD, 0x08 VALUE (RO), 0x0C STATUS (W1C).
// Build option: define TIMER_PRESCALER_EN to add CTRL[15:8] PRESC, giving
// one counter tick every PRESC+1 cycles; otherwise the counter ticks every
// cycle and CTRL[15:8] reads as zero.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic               hclk_i,
    input  logic               hreset_i,
    apb_timer_slave_if.slave   apb,
    output logic               irq_o
);

    localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    apb_state_t           r_state;
    logic [WCNT_W-1:0]    r_wcnt;

    logic                 r_en;
    logic                 r_autoReload;
    logic                 r_irqEn;
    logic [CNT_WIDTH-1:0] r_load;
    logic                 r_ovf;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_offset;
    logic                  w_selCtrl;
    logic                  w_selLoad;
    logic                  w_selValue;
    logic                  w_selStatus;
    logic                  w_err;
    logic                  w_done;
    logic                  w_wrEn;
    logic                  w_ctrlWr;
    logic                  w_loadWr;
    logic                  w_statusWr;
    logic                  w_startLoad;
    logic                  w_tick;
    logic [CNT_WIDTH-1:0]  w_value;
    logic                  w_underflow;
    logic [DATA_WIDTH-1:0] w_ctrlRd;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_addr   = apb.paddr_i;
    assign w_wdata  = apb.pwdata_i;
    assign w_offset = w_addr[7:0];

    // Offsets are word aligned, so a misaligned address never matches.
    assign w_selCtrl   = (w_offset == CTRL_OFF);
    assign w_selLoad   = (w_offset == LOAD_OFF);
    assign w_selValue  = (w_offset == VALUE_OFF);
    assign w_selStatus = (w_offset == STATUS_OFF);
    assign w_err = !(w_selCtrl || w_selLoad || w_selValue || w_selStatus)
                   || (apb.pwrite_i && w_selValue);

    assign w_done = (r_state == ACCESS) && apb.psel_i && apb.penable_i
                    && (r_wcnt == '0);

    assign w_wrEn      = w_done && apb.pwrite_i && !w_err;
    assign w_ctrlWr    = w_wrEn && w_selCtrl;
    assign w_loadWr    = w_wrEn && w_selLoad;
    assign w_statusWr  = w_wrEn && w_selStatus;
    assign w_startLoad = w_ctrlWr && w_wdata[CTRL_EN_BIT] && !r_en;

    always_ff @(posedge hclk_i or negedge hreset_i) begin
        if (!hreset_i) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (apb.psel_i && !apb.penable_i) begin
                        r_state <= ACCESS;
                        r_wcnt  <= WCNT_W'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (!apb.psel_i) begin
                        r_state <= IDLE;
                    end else if (apb.penable_i) begin
                        if (r_wcnt != '0) begin
                            r_wcnt <= r_wcnt - WCNT_W'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A CTRL write takes priority over the hardware EN clear, and an
    // underflow setting OVF takes priority over a same-cycle W1C.
    always_ff @(posedge hclk_i or negedge hreset_i) begin
        if (!hreset_i) begin
            r_en         <= 1'b0;
            r_autoReload <= 1'b0;
            r_irqEn      <= 1'b0;
            r_load       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_ctrlWr) begin
                r_en         <= w_wdata[CTRL_EN_BIT];
                r_autoReload <= w_wdata[CTRL_AR_BIT];
                r_irqEn      <= w_wdata[CTRL_IRQ_BIT];
            end else if (w_underflow && !r_autoReload) begin
                r_en <= 1'b0;
            end
            if (w_loadWr) begin
                r_load <= w_wdata[CNT_WIDTH-1:0];
            end
            if (w_underflow) begin
                r_ovf <= 1'b1;
            end else if (w_statusWr && w_wdata[STATUS_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef TIMER_PRESCALER_EN
    logic [7:0] r_presc;
    logic [7:0] r_pcnt;

    assign w_tick = r_en && (r_pcnt == r_presc);

    // Prescale count restarts from zero each time the timer is started.
    always_ff @(posedge hclk_i or negedge hreset_i) begin
        if (!hreset_i) begin
            r_presc <= '0;
            r_pcnt  <= '0;
        end else begin
            if (w_ctrlWr) begin
                r_presc <= w_wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
            end
            if (w_startLoad) begin
                r_pcnt <= '0;
            end else if (r_en) begin
                r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
            end
        end
    end
`else
    assign w_tick = r_en;
`endif

    timer_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer_core (
        .i_clk        (hclk_i),
        .i_rstN       (hreset_i),
        .i_tick       (w_tick),
        .i_load       (w_startLoad),
        .i_loadValue  (r_load),
        .i_autoReload (r_autoReload),
        .o_value      (w_value),
        .o_underflow  (w_underflow)
    );

    always_comb begin
        w_ctrlRd = '0;
        w_ctrlRd[CTRL_EN_BIT]  = r_en;
        w_ctrlRd[CTRL_AR_BIT]  = r_autoReload;
        w_ctrlRd[CTRL_IRQ_BIT] = r_irqEn;
`ifdef TIMER_PRESCALER_EN
        w_ctrlRd[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = r_presc;
`endif
    end

    always_comb begin
        w_rdata = '0;
        if (w_selCtrl) begin
            w_rdata = w_ctrlRd;
        end else if (w_selLoad) begin
            w_rdata = DATA_WIDTH'(r_load);
        end else if (w_selValue) begin
            w_rdata = DATA_WIDTH'(w_value);
        end else if (w_selStatus) begin
            w_rdata[STATUS_OVF_BIT] = r_ovf;
        end
    end

    assign apb.pready_o  = w_done;
    assign apb.pslverr_o = w_done && w_err;
    assign apb.prdata_o  = (w_done && !apb.pwrite_i && !w_err) ? w_rdata : '0;

    assign irq_o = r_ovf && r_irqEn;

endmodule
